// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the select lines of a 16:1 mux stage and waits a
// settle time on each channel. The mux output is sampled once per channel
// into a 16-bit frame. Finished frames go downstream on a valid/ready
// handshake. A frame that completes while the previous one is still
// unaccepted is dropped and flagged on a sticky overrun bit.
module mux_scan_ctrl #(
    parameter int SETTLE     = 1,     // cycles per channel, 1..15
    parameter bit CONTINUOUS = 1'b0   // 1: rescan back-to-back until stop_i
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        mux_i,
    output logic [3:0]  sel_o,
    output logic        busy_o,
    output logic [15:0] frame_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overrun_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] shadow_q, shadow_d;   // channels 0..14; channel 15 comes straight from mux_i
    logic [15:0] frame_q, frame_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        stop_q, stop_d;

    logic        accept;
    logic        complete;
    logic        stop_now;
    logic [15:0] candidate;

    // Next-state logic: scan sequencing, channel capture and output handshake
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        stop_d    = stop_q;
        complete  = 1'b0;
        accept    = valid_q & ready_i;
        candidate = {mux_i, shadow_q};
        // A stop arriving on the completion edge itself also ends the scan.
        stop_now  = stop_q | ((CONTINUOUS == 1'b1) & stop_i);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = SCAN;
                    sel_d     = 4'd0;
                    cnt_d     = RELOAD;
                    overrun_d = 1'b0;
                    stop_d    = 1'b0;
                end
            end
            SCAN: begin
                if ((CONTINUOUS == 1'b1) && stop_i) begin
                    stop_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    cnt_d = RELOAD;
                    sel_d = sel_q + 4'd1;   // wraps 15 -> 0
                    for (int b = 0; b < 15; b++) begin
                        if (sel_q == 4'(b)) begin
                            shadow_d[b] = mux_i;
                        end
                    end
                    if (sel_q == 4'd15) begin
                        complete = 1'b1;
                        if ((CONTINUOUS == 1'b0) || stop_now) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (!valid_q || accept) begin
                frame_d = candidate;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            cnt_q     <= 4'd0;
            shadow_q  <= 15'd0;
            frame_q   <= 16'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            stop_q    <= stop_d;
        end
    end

    assign sel_o     = sel_q;
    assign busy_o    = (state_q == SCAN);
    assign frame_o   = frame_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl. It runs three instances side by side:
// one-shot SETTLE=1, one-shot SETTLE=3 and continuous SETTLE=1.
// Each instance sees its own 16-bit pattern on the mux inputs.
// A reference model tracks elapsed cycles since start and derives the
// channel and capture points arithmetically from SETTLE.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, ready;
    logic [15:0] pat [3];
    logic [2:0]  mux_w;
    logic [3:0]  sel_w [3];
    logic        busy_w [3];
    logic [15:0] frame_w [3];
    logic        valid_w [3];
    logic        ovr_w [3];

    int checks = 0;
    int errors = 0;

    // reference model state
    int          S_T [3] = '{1, 3, 1};
    bit          C_T [3] = '{1'b0, 1'b0, 1'b1};
    bit          m_busy [3];
    int          m_el [3];          // cycles elapsed since the start edge
    bit          m_stop [3];
    logic [15:0] m_cap [3];
    logic [15:0] m_frame [3];
    bit          m_valid [3];
    bit          m_ovr [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mux_scan_ctrl #(
            .SETTLE    ((gi == 1) ? 3 : 1),
            .CONTINUOUS((gi == 2) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .start_i  (start),
            .stop_i   (stop),
            .mux_i    (mux_w[gi]),
            .sel_o    (sel_w[gi]),
            .busy_o   (busy_w[gi]),
            .frame_o  (frame_w[gi]),
            .valid_o  (valid_w[gi]),
            .ready_i  (ready),
            .overrun_o(ovr_w[gi])
        );
        assign mux_w[gi] = pat[gi][sel_w[gi]];
    end

    function automatic logic [3:0] model_sel(input int i);
        return m_busy[i] ? 4'((m_el[i] / S_T[i]) % 16) : 4'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 0; m_el[i] = 0; m_stop[i] = 0; m_cap[i] = '0;
            m_frame[i] = '0; m_valid[i] = 0; m_ovr[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit acc, comp;
            int ch;
            logic mux;
            acc  = m_valid[i] && ready;
            comp = 0;
            if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i] = 1; m_el[i] = 0; m_ovr[i] = 0; m_stop[i] = 0;
                end
            end else begin
                mux = pat[i][model_sel(i)];
                m_el[i]++;
                if (C_T[i] && stop) m_stop[i] = 1;
                if (m_el[i] % S_T[i] == 0) begin
                    ch = (m_el[i] / S_T[i] - 1) % 16;
                    m_cap[i][ch] = mux;
                    if (ch == 15) begin
                        comp = 1;
                        if (!C_T[i] || m_stop[i]) begin
                            m_busy[i] = 0; m_el[i] = 0; m_stop[i] = 0;
                        end
                    end
                end
            end
            if (comp) begin
                if (!m_valid[i] || acc) begin
                    m_frame[i] = m_cap[i];
                    m_valid[i] = 1;
                    $display("frame inst=%0d value=%h", i, m_cap[i]);
                end else begin
                    m_ovr[i] = 1;
                    $display("frame inst=%0d value=%h dropped", i, m_cap[i]);
                end
            end else if (acc) begin
                m_valid[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int inst, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] got=%h exp=%h", tag, inst, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("sel",     i, {12'd0, sel_w[i]},    {12'd0, model_sel(i)});
            chk("busy",    i, {15'd0, busy_w[i]},   {15'd0, m_busy[i]});
            chk("frame",   i, frame_w[i],           m_frame[i]);
            chk("valid",   i, {15'd0, valid_w[i]},  {15'd0, m_valid[i]});
            chk("overrun", i, {15'd0, ovr_w[i]},    {15'd0, m_ovr[i]});
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic stop_cont();
        stop = 1'b1; cycle(); stop = 1'b0;
        run(20);
        chk("stopped_busy", 2, {15'd0, busy_w[2]}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
        pat[0] = 16'hA5C3; pat[1] = 16'h8001; pat[2] = 16'h1234;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // one-shot frames with ready held high
        ready = 1'b1;
        pulse_start();
        run(15);
        chk("pre_valid", 0, {15'd0, valid_w[0]}, 16'd0);
        cycle();
        chk("s1_frame", 0, frame_w[0], 16'hA5C3);
        chk("s1_valid", 0, {15'd0, valid_w[0]}, 16'd1);
        chk("s1_busy",  0, {15'd0, busy_w[0]},  16'd0);
        run(31);
        chk("s3_pre_valid", 1, {15'd0, valid_w[1]}, 16'd0);
        cycle();
        chk("s3_frame", 1, frame_w[1], 16'h8001);
        chk("s3_valid", 1, {15'd0, valid_w[1]}, 16'd1);
        stop_cont();

        // continuous overrun with ready low
        ready = 1'b0;
        pulse_start();
        run(15);
        pat[2] = 16'h5678;
        run(1);
        chk("c_first", 2, frame_w[2], 16'h1234);
        run(16);
        chk("c_ovr",   2, {15'd0, ovr_w[2]}, 16'd1);
        chk("c_hold",  2, frame_w[2], 16'h1234);
        stop_cont();

        // accept coinciding with completion of frame 2
        ready = 1'b1;
        pat[2] = 16'h0F0F;
        pulse_start();
        ready = 1'b0;
        run(16);
        chk("c_f1", 2, frame_w[2], 16'h0F0F);
        pat[2] = 16'hBEEF;
        run(15);
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        chk("c_f2",     2, frame_w[2], 16'hBEEF);
        chk("c_f2_val", 2, {15'd0, valid_w[2]}, 16'd1);
        chk("c_f2_ovr", 2, {15'd0, ovr_w[2]},   16'd0);
        stop_cont();

        // asynchronous reset at channel 7, then a clean frame
        ready = 1'b1;
        pulse_start();
        run(7);
        chk("at_ch7", 0, {12'd0, sel_w[0]}, 16'd7);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        pat[0] = 16'h3C5A;
        pulse_start();
        run(16);
        chk("post_rst", 0, frame_w[0], 16'h3C5A);
        stop_cont();

        // stop at channel 3 and restart attempt at channel 5 in continuous mode
        pat[2] = 16'h9A6C;
        pulse_start();
        run(3);
        stop = 1'b1; cycle(); stop = 1'b0;
        run(1);
        start = 1'b1; cycle(); start = 1'b0;
        run(10);
        chk("stop_frame", 2, frame_w[2], 16'h9A6C);
        chk("stop_busy",  2, {15'd0, busy_w[2]}, 16'd0);
        run(3);
        chk("stop_idle",  2, {15'd0, busy_w[2]}, 16'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) pat[i] = 16'($urandom);
            ready = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
